// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Produces {remainder, quotient}. A normal divide takes DATA_W+1 cycles.
// A divide by zero takes 1 cycle and returns 0.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic                ready_o,
    output logic [2*DATA_W-1:0] result_o
);
    localparam int               CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t state, state_n;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;   // dividend bits shift out of the MSB; quotient bits shift into the LSB
    logic [DATA_W-1:0] dsr;   // divisor magnitude
    logic [DATA_W-1:0] rem;   // partial remainder; it is always below the divisor, so DATA_W bits suffice
    logic              neg1;  // dividend was negative (signed mode only)
    logic              neg2;  // divisor was negative (signed mode only)

    logic              op1_neg, op2_neg, accept, div_zero;
    logic [DATA_W:0]   shifted, diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_n, quo_fix, rem_fix;

    // Operand preparation, one restoring step, and the final sign fix-up.
    always_comb begin
        op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
        accept   = start_i & ~annul_i;
        div_zero = (opdata2_i == '0);
        shifted  = {rem, dvd[DATA_W-1]};
        // The shifted value is below 2*divisor, so a DATA_W+1 bit difference has the correct sign in its MSB.
        diff     = shifted - {1'b0, dsr};
        q_bit    = ~diff[DATA_W];
        rem_n    = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_fix  = (neg1 ^ neg2) ? -dvd : dvd;
        rem_fix  = neg1 ? -rem : rem;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FREE;
        else     state <= state_n;
    end

    // Next-state logic. An annul takes priority over completion.
    always_comb begin
        state_n = state;
        case (state)
            FREE:    if (accept) state_n = div_zero ? BYZERO : ON;
            BYZERO:  state_n = END;
            ON:      if (annul_i) state_n = FREE;
                     else if (cnt == LAST) state_n = END;
            END:     if (!start_i) state_n = FREE;
            default: state_n = FREE;
        endcase
    end

    // Datapath: operand latch, iteration, and registered result/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (accept && !div_zero) begin
                        neg1 <= op1_neg;
                        neg2 <= op2_neg;
                        dvd  <= op1_neg ? -opdata1_i : opdata1_i;
                        dsr  <= op2_neg ? -opdata2_i : opdata2_i;
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                BYZERO: begin
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        ready_o <= 1'b0;
                    end else if (cnt == LAST) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        rem <= rem_n;
                        dvd <= {dvd[DATA_W-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div.
// Stimulus pushes the expected {rem, quo} and latency.
// The monitor pops and compares each entry on every rising edge of ready_o.
module tb_div;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div, start, annul;
    logic [W-1:0]   op1, op2;
    logic           ready;
    logic [2*W-1:0] result;

    div #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .ready_o      (ready),
        .result_o     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic prev_ready  = 1'b0;

    // Count rising edges; a start driven at a negedge takes effect at edge cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising edge of ready_o must match the oldest expected result and latency.
    always @(negedge clk) begin
        exp_t e;
        if (ready && !prev_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: ready_o rose with nothing outstanding, result=%h", result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || (cyc - e.e0) != e.lat) begin
                    miscompares++;
                    $display("FAIL %s: got result=%h latency=%0d, want result=%h latency=%0d",
                             e.name, result, cyc - e.e0, e.res, e.lat);
                end
            end
        end
        prev_ready = ready;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive a request at the current negedge and optionally post its expected response.
    task automatic issue(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] want, input int lat, input bit push);
        exp_t e;
        signed_div = s;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        if (push) begin
            e.name = name;
            e.res  = want;
            e.e0   = cyc + 1;
            e.lat  = lat;
            sb.push_back(e);
        end
    endtask

    // Wait for ready_o while scrambling the operands, which must be ignored after the start edge.
    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            op1        = $urandom;
            op2        = $urandom;
            signed_div = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: ready_o still 0 after %0d cycles, want 1", name, n);
            sb.delete();
        end
    endtask

    // Hold start for one more edge, then drop it; END must hold, then clear.
    task automatic drop(input string name, input logic [63:0] want);
        @(negedge clk);
        check({name, "_held_ready"}, 64'(ready), 64'd1);
        check({name, "_held_result"}, result, want);
        start = 1'b0;
        @(negedge clk);
        check({name, "_clr_ready"}, 64'(ready), 64'd0);
        check({name, "_clr_result"}, result, 64'd0);
    endtask

    task automatic run(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] want, input int lat);
        @(negedge clk);
        issue(name, s, a, b, want, lat, 1'b1);
        wait_done(name);
        drop(name, want);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        #12;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("udiv_100_7",     1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33);
        run("sdiv_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   33);
        run("sdiv_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   33);
        run("div_by_zero",    1'b0, 32'h12345678,   32'd0,          64'd0,                            1);
        run("udiv_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF},   33);
        run("sdiv_overflow",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   33);
        run("udiv_small",     1'b0, 32'd5,          32'd9,          {32'd5,          32'd0},          33);
        run("sdiv_small_neg", 1'b1, 32'hFFFFFFFB,   32'd9,          {32'hFFFFFFFB,   32'd0},          33);
        run("udiv_big_dsr",   1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0},          33);
        run("sdiv_by_zero",   1'b1, 32'h80000000,   32'd0,          64'd0,                            1);

        // An annul on E10, then a new 9/3 accepted on the very next edge.
        @(negedge clk);
        issue("annulled", 1'b0, 32'd100, 32'd7, 64'd0, 33, 1'b0);
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check("annul_e10_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        issue("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);
        wait_done("after_annul");
        drop("after_annul", {32'd0, 32'd3});

        // An annul on the completion edge (E33) wins, so no result is published.
        @(negedge clk);
        issue("annul_last", 1'b0, 32'd100, 32'd7, 64'd0, 33, 1'b0);
        repeat (33) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check("annul_e33_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("annul_e33_idle", 64'(ready), 64'd0);

        // start together with annul in FREE is ignored. A wrongly accepted divide would show up as an unexpected ready.
        @(negedge clk);
        issue("start_annul", 1'b0, 32'd100, 32'd7, 64'd0, 33, 1'b0);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("start_annul_idle", 64'(ready), 64'd0);

        // Async reset while ON (counter 20), then a normal divide right after release.
        @(negedge clk);
        issue("reset_on", 1'b0, 32'd100, 32'd7, 64'd0, 33, 1'b0);
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_on_ready", 64'(ready), 64'd0);
        check("async_rst_on_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue("after_reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
        wait_done("after_reset");

        // Async reset while END holds a result clears the outputs before any edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_end_ready", 64'(ready), 64'd0);
        check("async_rst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Stop a runaway simulation.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, want completion");
        $fatal(1);
    end
endmodule

// File: doc/div.md
# div

Multi-cycle radix-2 restoring divider for the OpenMIPS execute stage. It serves DIV and DIVU: it accepts two operands from EX, iterates one quotient bit per cycle, and returns a 64-bit result that EX forwards to the HI/LO write path. EX stalls the pipeline while the divider is busy and can annul an in-flight divide on a flush. Clock and reset come from the same top-level `clk`/`rst` that drive `openmips_min_sopc`.

## Interface
- `DATA_W`, default 32: operand width. The result is 2*DATA_W wide. The iteration count equals DATA_W.
- `clk`, input, 1: system clock. All state changes occur on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `signed_div_i`, input, 1: 1 selects signed (DIV), 0 selects unsigned (DIVU). Sampled only on the start edge.
- `opdata1_i`, input, DATA_W: dividend. Sampled only on the start edge.
- `opdata2_i`, input, DATA_W: divisor. Sampled only on the start edge.
- `start_i`, input, 1: request. Held high by EX until it has seen `ready_o`.
- `annul_i`, input, 1: abort the current divide (pipeline flush).
- `ready_o`, output, 1: result valid (registered).
- `result_o`, output, 2*DATA_W: {remainder, quotient}. Remainder is in [63:32] and quotient is in [31:0] for DATA_W=32 (registered).

## Operation
- The FSM has four states: FREE, BYZERO, ON, END. Reset places it in FREE with `ready_o`=0, `result_o`=0, and the iteration counter at 0.
- **FREE**
  - If `start_i`=1 and `annul_i`=0: when the divisor is 0, go to BYZERO; otherwise latch the operands and go to ON with the counter at 0.
  - If `start_i` and `annul_i` are both 1, the request is ignored and the block stays in FREE.
- **Signed operand preparation.** In signed mode, each negative operand is replaced by its two's-complement magnitude before iteration. The original sign bits are kept.
- **ON, per cycle while counter < DATA_W**
  - Shift the partial remainder left and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor magnitude in DATA_W+1 bits.
  - If the difference is non-negative, keep it and shift in quotient bit 1. Otherwise keep the shifted remainder and shift in 0.
  - Increment the counter.
- **ON, counter = DATA_W**
  - Apply the signed fix-up: negate the quotient if sign1^sign2, and negate the remainder if sign1. Unsigned mode has no fix-up.
  - Register the result, set `ready_o`=1, and go to END.
- **ON with annul_i=1** on any edge: go to FREE with `ready_o`=0. Partial state is discarded.
- **BYZERO:** on the next edge go to END with `result_o`=0 and `ready_o`=1.
- **END:** hold `ready_o`=1 and `result_o` while `start_i`=1. On an edge with `start_i`=0, go to FREE, clear `ready_o`=0 and `result_o`=0.
- **Corner cases** (no special-casing beyond BYZERO):
  - The most-negative dividend divided by -1 (signed) wraps to quotient 0x80000000, remainder 0, matching unspecified MIPS behaviour.
  - A dividend smaller in magnitude than the divisor gives quotient 0, remainder = dividend.
- **Operand changes:** changes to `opdata*_i` or `signed_div_i` after the start edge have no effect.

## Timing
- **Latency.** Call the start edge E0 (FREE→ON).
  - Iterations occur on E1..E32.
  - On E33 the state goes ON→END. `ready_o` is first high after E33: 33 cycles after start, for DATA_W=32. In general the latency is DATA_W+1.
- **Divide by zero:** E0 goes FREE→BYZERO and E1 goes BYZERO→END, so `ready_o` is high after E1.
- **Back-to-back divides:** `start_i` must drop for at least one edge (END→FREE) before the next start is accepted.
- **Annul vs. completion:** annul takes priority over completion on the same edge, including the counter=DATA_W edge. In that case the result is not published.
- **Annul in END or BYZERO:** ignored. EX clears the request via `start_i`.
- **Reset:** asserting `rst` mid-operation immediately forces FREE, `ready_o`=0, and `result_o`=0, with no clock required. The first start after release is accepted on the first rising edge with `rst`=0.

## Test plan
- **Unsigned divide.** Unsigned 100/7, start held high. Required: `ready_o` rises after E33; `result_o` = {0x00000002, 0x0000000E}. Then drop `start_i`: `ready_o`=0 and `result_o`=0 after the next edge.
- **Signed signs.** Signed -7/2 (0xFFFFFFF9/0x00000002). Required: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7/-2. Required: quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero.** Divide 0x12345678 by 0. Required: `ready_o` high after E1, `result_o`=0. Then drop `start_i`, issue 0xFFFFFFFF/1 unsigned. Required: quotient 0xFFFFFFFF, remainder 0 after E33.
- **Annul.** Assert `annul_i` on E10 of a divide. Required: `ready_o` never rises and the FSM returns to FREE. A new 9/3 started on the following edge returns quotient 3, remainder 0 exactly 33 edges later.
- **Async reset.** Assert `rst` between edges while in ON (counter 20). Required: `ready_o`=0 and `result_o`=0 before the next edge. After release, 100/7 completes normally with 33-cycle latency.
- **Signed overflow.** Signed 0x80000000 / 0xFFFFFFFF. Required: quotient 0x80000000, remainder 0x00000000, no hang.
